// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset main control, Moore-decoded 4-bit state (define MC_ADDI_EN for addi).
// Latency: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles, plus memory wait; outputs track state same cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; mem_ready is ignored elsewhere.
module mc_control_fsm #(
    parameter logic [5:0] OPC_RTYPE = 6'b000000,
    parameter logic [5:0] OPC_LW    = 6'b100011,
    parameter logic [5:0] OPC_SW    = 6'b101011,
    parameter logic [5:0] OPC_BEQ   = 6'b000100,
    parameter logic [5:0] OPC_J     = 6'b000010,
    parameter logic [5:0] OPC_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MC_ADDI_EN
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
`else
        JUMP   = 4'd9
`endif
    } state_t;

    state_t state_q;
    state_t state_d;
    // Opcode is only valid in DECODE, so MEMADR needs a remembered lw/sw choice.
    logic   is_sw_q;

    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                is_sw_q <= (Opcode == OPC_SW);
            end
        end
    end

    always_comb begin
        state_d       = FETCH;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (Opcode)
                    OPC_LW, OPC_SW: state_d = MEMADR;
                    OPC_RTYPE:      state_d = EXEC;
                    OPC_BEQ:        state_d = BRANCH;
                    OPC_J:          state_d = JUMP;
`ifdef MC_ADDI_EN
                    OPC_ADDI:       state_d = ADDIEX;
`else
                    OPC_ADDI: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_sw_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign ALUOp    = alu_op;
    assign ALUSrcA  = alu_src_a;
    assign ALUSrcB  = alu_src_b;
    assign PCSource = pc_source;
    assign IorD     = iord;
    assign MemRead  = mem_read;
    assign MemtoReg = mem_to_reg;
    assign RegDst   = reg_dst;
    assign state    = state_q;

    // FETCH strobes follow mem_ready combinationally, so gate them while reset is held.
    assign PCWrite     = pc_write & rst_n;
    assign PCWriteCond = pc_write_cond & rst_n;
    assign IRWrite     = ir_write & rst_n;
    assign MemWrite    = mem_write & rst_n;
    assign RegWrite    = reg_write & rst_n;
    assign illegal_op  = illegal & rst_n;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main control unit for the MIPS-subset datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives all datapath enables.
- Produces the 2-bit ALUOp that feeds the downstream ALU control decoder: 00 = add (address/PC), 01 = subtract (beq), 10 = decode funct field.
- Stalls on a memory-ready handshake.

Parameters:
- OPC_RTYPE, 6'b000000, R-type opcode
- OPC_LW, 6'b100011, load word opcode
- OPC_SW, 6'b101011, store word opcode
- OPC_BEQ, 6'b000100, branch-equal opcode
- OPC_J, 6'b000010, jump opcode
- OPC_ADDI, 6'b001000, add-immediate opcode (used only with MC_ADDI_EN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  IR[31:26]; sampled in DECODE only
- mem_ready  in  1  memory completes access this cycle
- ALUOp  out  2  to ALU control decoder
- ALUSrcA  out  1  0 = PC, 1 = rs register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite  out  1 each  standard multicycle enables
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state encoding, for debug

Behaviour:
- Clocking and reset:
  - One clock domain; single 4-bit state register.
  - All outputs are Moore (decoded from the registered state), except the mem_ready-gated strobes listed below.
  - rst_n low: state = FETCH(0) immediately.
  - While rst_n is low, every write strobe (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) is forced to 0, and illegal_op = 0.
  - Reset mid-instruction abandons it; there is no partial writeback after reset.
- State encoding and outputs (all signals not listed are 0; ALUOp defaults to 00):
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite = PCWrite = mem_ready. Advance to DECODE only when mem_ready=1; otherwise hold with no PC/IR update.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by Opcode: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDIEX (macro only). Any other opcode -> FETCH, with illegal_op=1 for that DECODE cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MemRead=1, IorD=1. Hold until mem_ready, then -> MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Hold until mem_ready, then -> FETCH. MemWrite stays asserted throughout the wait.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP(9): PCWrite=1, PCSource=10 -> FETCH.
  - ADDIEX(10), ADDIWB(11): see optional feature.
  - Codes 12–15 unused; any unused code -> FETCH next cycle with all strobes 0.
- Latency in cycles, excluding memory wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Opcode is sampled only in DECODE.

Optional Feature:
- MC_ADDI_EN defined:
  - DECODE with Opcode == OPC_ADDI -> ADDIEX.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- MC_ADDI_EN undefined:
  - ADDIEX/ADDIWB do not exist (codes 10–11 unused).
  - OPC_ADDI is treated as illegal: illegal_op pulse, return to FETCH.

Test Plan:
- Reset: hold rst_n=0 with mem_ready=1 -> state=0, PCWrite=IRWrite=RegWrite=MemWrite=0. Release rst_n -> PCWrite=1, IRWrite=1 in the first cycle.
- R-type: Opcode=000000 with mem_ready=1 -> state sequence 0,1,6,7,0. ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
- lw with stall: Opcode=100011, mem_ready low for 3 cycles in MEMRD -> state 3 held for 4 cycles with MemRead=1, IorD=1, then 4 (RegWrite=1, MemtoReg=1), then 0.
- sw then beq: sw gives 0,1,2,5,0 with MemWrite=1 only in state 5. beq gives 0,1,8,0 with ALUOp=01 and PCWriteCond=1 in state 8.
- Jump/illegal: Opcode=000010 -> 0,1,9,0 with PCSource=10 and PCWrite=1. Opcode=111111 -> illegal_op=1 for exactly one cycle in state 1, then state 0.
- addi both builds: Opcode=001000 -> with MC_ADDI_EN: 0,1,10,11,0, RegWrite=1 in state 11. Without MC_ADDI_EN: illegal_op pulse, return to 0.
- Mid-instruction reset: assert rst_n=0 during state 5 -> MemWrite drops to 0 immediately, state=0.
